// File: rtl/row_package_feeder.sv
// Collects streamed word pairs into NI-wide packages, presents each for one cycle and then
// holds it for HOLD cycles; the downstream consumer paces rows via prepare_my_new_input_i.
module row_package_feeder #(
  parameter int unsigned NOE      = 10,
  parameter int unsigned NI       = 8,
  parameter int unsigned HOLD     = 3,
  parameter int unsigned NUM_ROWS = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            word_valid_i,
  input  logic [31:0]     first_word_i,
  input  logic [31:0]     second_word_i,
  output logic            word_ready_o,
  output logic [32*NI-1:0] first_row_input_o,
  output logic [32*NI-1:0] second_row_input_o,
  output logic            outsider_read_now_o,
  output logic [31:0]     no_of_multiples_o,
  input  logic            prepare_my_new_input_i,
  output logic            row_done_o,
  output logic            busy_o
);

  localparam int unsigned KW = (NI > 1) ? $clog2(NI + 1) : 1;
  localparam int unsigned EW = (NOE > 1) ? $clog2(NOE) : 1;
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [31:0] NumMultiples = 32'((NOE + NI - 1) / NI);

  typedef enum logic [2:0] {StIdle, StFill, StPresent, StHold, StWaitRow} state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [EW-1:0]      elem_q, elem_d;
  logic [RW-1:0]      row_q, row_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               flag_q, flag_d;
  logic               last_q, last_d;
  logic               row_done_q, row_done_d;
  logic [32*NI-1:0]   pkg1_q, pkg1_d, pkg2_q, pkg2_d;
  int unsigned        slot_lsb;

  // Slot k lives at the MSB end first: slot 0 occupies the top 32 bits.
  assign slot_lsb = 32 * (NI - 1 - 32'(k_q));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    elem_d     = elem_q;
    row_d      = row_q;
    hold_d     = hold_q;
    flag_d     = flag_q;
    last_d     = last_q;
    pkg1_d     = pkg1_q;
    pkg2_d     = pkg2_q;

    if (prepare_my_new_input_i && ((state_q == StHold && last_q) || state_q == StWaitRow)) begin
      flag_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFill;
      end
      StFill: begin
        if (word_valid_i) begin
          pkg1_d[slot_lsb +: 32] = first_word_i;
          pkg2_d[slot_lsb +: 32] = second_word_i;
          k_d = k_q + 1'b1;
          if (elem_q == EW'(NOE - 1)) begin
            elem_d  = '0;
            last_d  = 1'b1;
            state_d = StPresent;
          end else begin
            elem_d = elem_q + 1'b1;
            if (k_q == KW'(NI - 1)) state_d = StPresent;
          end
        end
      end
      StPresent: begin
        hold_d  = '0;
        state_d = StHold;
      end
      StHold: begin
        if (hold_q == HW'(HOLD - 1)) begin
          state_d = last_q ? StWaitRow : StFill;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StWaitRow: begin
        // A pulse arriving in WAIT_ROW itself releases the row without an extra cycle.
        if (flag_q || prepare_my_new_input_i) begin
          flag_d = 1'b0;
          if (row_q == RW'(NUM_ROWS - 1)) begin
            row_d   = '0;
            state_d = StIdle;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StFill && state_q != StFill) begin
      pkg1_d = '0;
      pkg2_d = '0;
      k_d    = '0;
      last_d = 1'b0;
    end
    if (state_d == StIdle && state_q != StIdle) begin
      elem_d = '0;
      row_d  = '0;
    end
    row_done_d = (state_d == StWaitRow) && (state_q != StWaitRow);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      k_q        <= '0;
      elem_q     <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      flag_q     <= 1'b0;
      last_q     <= 1'b0;
      row_done_q <= 1'b0;
      pkg1_q     <= '0;
      pkg2_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      elem_q     <= elem_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      flag_q     <= flag_d;
      last_q     <= last_d;
      row_done_q <= row_done_d;
      pkg1_q     <= pkg1_d;
      pkg2_q     <= pkg2_d;
    end
  end

  assign word_ready_o        = (state_q == StFill);
  assign outsider_read_now_o = (state_q == StPresent);
  assign busy_o              = (state_q != StIdle);
  assign row_done_o          = row_done_q;
  assign first_row_input_o   = pkg1_q;
  assign second_row_input_o  = pkg2_q;
  assign no_of_multiples_o   = NumMultiples;

endmodule

// File: tb/tb_row_package_feeder.sv
// Directed bench for row_package_feeder: default instance plus a NOE=16, NUM_ROWS=2 instance.
module tb_row_package_feeder;

  logic clk, rst_n;
  logic start, word_valid, prep;
  logic [31:0] fw, sw;
  logic ready, read_now, row_done, busy;
  logic [255:0] pkg1, pkg2;
  logic [31:0] nom;

  logic start2, valid2, prep2;
  logic [31:0] fw2, sw2;
  logic ready2, read_now2, row_done2, busy2;
  logic [255:0] pkg1b, pkg2b;
  logic [31:0] nom2;

  int checks = 0;
  int errors = 0;

  logic [255:0] cap1 [4];
  logic [255:0] cap2 [4];
  int pulse_cyc [4];
  int n_pulses, done_cyc;
  bit done_seen;

  row_package_feeder dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .word_valid_i(word_valid),
    .first_word_i(fw), .second_word_i(sw), .word_ready_o(ready),
    .first_row_input_o(pkg1), .second_row_input_o(pkg2), .outsider_read_now_o(read_now),
    .no_of_multiples_o(nom), .prepare_my_new_input_i(prep), .row_done_o(row_done),
    .busy_o(busy)
  );

  row_package_feeder #(.NOE(16), .NI(8), .HOLD(3), .NUM_ROWS(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .word_valid_i(valid2),
    .first_word_i(fw2), .second_word_i(sw2), .word_ready_o(ready2),
    .first_row_input_o(pkg1b), .second_row_input_o(pkg2b), .outsider_read_now_o(read_now2),
    .no_of_multiples_o(nom2), .prepare_my_new_input_i(prep2), .row_done_o(row_done2),
    .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] mk_pkg(input int off, input int first, input int n);
    logic [255:0] p;
    p = '0;
    for (int k = 0; k < n; k++) p[32*(7-k) +: 32] = 32'(off + first + k);
    return p;
  endfunction

  // Acts as the word source and records every presented package until row_done.
  task automatic feed_row(input bit toggle, input bit prep_hold, input int stop_after);
    int elem;
    bit pend;
    elem = 0;
    pend = 0;
    n_pulses = 0;
    done_seen = 0;
    done_cyc = -1;
    for (int c = 0; c < 200; c++) begin
      if (elem >= stop_after && stop_after < 10) break;
      prep = pend;
      pend = 0;
      if (read_now) begin
        if (n_pulses < 4) begin
          cap1[n_pulses] = pkg1;
          cap2[n_pulses] = pkg2;
          pulse_cyc[n_pulses] = c;
        end
        n_pulses++;
        if (prep_hold && n_pulses == 2) pend = 1;
      end
      if (row_done) begin
        done_seen = 1;
        done_cyc = c;
        break;
      end
      word_valid = (elem < stop_after) && (!toggle || (c % 2 == 0));
      fw = 32'(elem + 1);
      sw = 32'(256 + elem + 1);
      if (word_valid && ready) elem++;
      @(posedge clk); #1;
    end
    word_valid = 0;
    prep = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (read_now !== 1'b0) begin errors++; $display("FAIL reset_read_now got %b want 0", read_now); end
    checks++; if (row_done !== 1'b0) begin errors++; $display("FAIL reset_row_done got %b want 0", row_done); end
    checks++; if (pkg1 !== '0 || pkg2 !== '0) begin errors++; $display("FAIL reset_pkgs got %h / %h want 0", pkg1, pkg2); end
    checks++; if (nom !== 32'd2) begin errors++; $display("FAIL reset_nom got %0d want 2", nom); end
    rst_n = 1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    pulse_start();
    feed_row(0, 0, 10);
    checks++; if (!done_seen || n_pulses != 2) begin errors++; $display("FAIL basic_pulses got %0d done %0d want 2 done 1", n_pulses, done_seen); end
    checks++; if (cap1[0] !== mk_pkg(0, 1, 8)) begin errors++; $display("FAIL basic_p1_first got %h want %h", cap1[0], mk_pkg(0, 1, 8)); end
    checks++; if (cap2[0] !== mk_pkg(256, 1, 8)) begin errors++; $display("FAIL basic_p1_second got %h want %h", cap2[0], mk_pkg(256, 1, 8)); end
    checks++; if (cap1[1] !== mk_pkg(0, 9, 2)) begin errors++; $display("FAIL basic_p2_first got %h want %h", cap1[1], mk_pkg(0, 9, 2)); end
    checks++; if (cap2[1] !== mk_pkg(256, 9, 2)) begin errors++; $display("FAIL basic_p2_second got %h want %h", cap2[1], mk_pkg(256, 9, 2)); end
    // PRESENT + 3 HOLD + 2 FILL cycles between pulses; PRESENT + 3 HOLD before row_done.
    checks++; if (pulse_cyc[1] - pulse_cyc[0] != 6) begin errors++; $display("FAIL basic_spacing got %0d want 6", pulse_cyc[1] - pulse_cyc[0]); end
    checks++; if (done_cyc - pulse_cyc[1] != 4) begin errors++; $display("FAIL basic_done_lat got %0d want 4", done_cyc - pulse_cyc[1]); end
    checks++; if (nom !== 32'd2) begin errors++; $display("FAIL basic_nom got %0d want 2", nom); end
  endtask

  task automatic test_wait_row();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      @(posedge clk); #1;
      if (ready !== 1'b0 || busy !== 1'b1 || row_done !== 1'b0) bad++;
    end
    start = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL wait_stall bad_cycles %0d want 0", bad); end
    prep = 1;
    @(posedge clk); #1;
    prep = 0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wait_release ready got %b want 1", ready); end
  endtask

  task automatic test_toggle();
    feed_row(1, 0, 10);
    checks++; if (!done_seen || n_pulses != 2) begin errors++; $display("FAIL toggle_pulses got %0d done %0d want 2 done 1", n_pulses, done_seen); end
    checks++; if (cap1[0] !== mk_pkg(0, 1, 8) || cap2[0] !== mk_pkg(256, 1, 8)) begin errors++; $display("FAIL toggle_p1 got %h / %h", cap1[0], cap2[0]); end
    checks++; if (cap1[1] !== mk_pkg(0, 9, 2) || cap2[1] !== mk_pkg(256, 9, 2)) begin errors++; $display("FAIL toggle_p2 got %h / %h", cap1[1], cap2[1]); end
    checks++; if (pulse_cyc[1] - pulse_cyc[0] != 8) begin errors++; $display("FAIL toggle_spacing got %0d want 8", pulse_cyc[1] - pulse_cyc[0]); end
    prep = 1;
    @(posedge clk); #1;
    prep = 0;
  endtask

  task automatic test_hold_prep();
    feed_row(0, 1, 10);
    checks++; if (!done_seen || n_pulses != 2) begin errors++; $display("FAIL holdprep_pulses got %0d done %0d want 2 done 1", n_pulses, done_seen); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || row_done !== 1'b0) begin errors++; $display("FAIL holdprep_exit ready %b row_done %b want 1 0", ready, row_done); end
  endtask

  task automatic test_midrow_reset();
    feed_row(0, 0, 6);
    rst_n = 0;
    #1;
    checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_ctl ready %b busy %b want 0 0", ready, busy); end
    checks++; if (read_now !== 1'b0 || row_done !== 1'b0) begin errors++; $display("FAIL midreset_pulses read_now %b row_done %b want 0 0", read_now, row_done); end
    checks++; if (pkg1 !== '0 || pkg2 !== '0) begin errors++; $display("FAIL midreset_pkgs got %h / %h want 0", pkg1, pkg2); end
    checks++; if (nom !== 32'd2) begin errors++; $display("FAIL midreset_nom got %0d want 2", nom); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    pulse_start();
    feed_row(0, 0, 10);
    checks++; if (!done_seen || n_pulses != 2) begin errors++; $display("FAIL restart_pulses got %0d done %0d want 2 done 1", n_pulses, done_seen); end
    checks++; if (cap1[0] !== mk_pkg(0, 1, 8) || cap2[0] !== mk_pkg(256, 1, 8)) begin errors++; $display("FAIL restart_p1 got %h / %h", cap1[0], cap2[0]); end
    checks++; if (cap1[1] !== mk_pkg(0, 9, 2) || cap2[1] !== mk_pkg(256, 9, 2)) begin errors++; $display("FAIL restart_p2 got %h / %h", cap1[1], cap2[1]); end
  endtask

  task automatic test_noe16();
    int np, nd, bad;
    np = 0;
    nd = 0;
    bad = 0;
    valid2 = 1;
    prep2 = 1;
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    for (int c = 0; c < 300; c++) begin
      if (read_now2) begin
        np++;
        for (int k = 0; k < 8; k++) begin
          if (pkg1b[32*k +: 32] == 32'h0 || pkg2b[32*k +: 32] == 32'h0) bad++;
        end
      end
      if (row_done2) begin
        nd++;
        if (nd == 2) break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid2 = 0;
    prep2 = 0;
    checks++; if (np != 4) begin errors++; $display("FAIL n16_pulses got %0d want 4", np); end
    checks++; if (nd != 2) begin errors++; $display("FAIL n16_rows got %0d want 2", nd); end
    checks++; if (bad != 0) begin errors++; $display("FAIL n16_padded got %0d zero slots want 0", bad); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL n16_busy got %b want 0", busy2); end
    checks++; if (nom2 !== 32'd2) begin errors++; $display("FAIL n16_nom got %0d want 2", nom2); end
  endtask

  initial begin
    rst_n = 0;
    start = 0; word_valid = 0; prep = 0; fw = '0; sw = '0;
    start2 = 0; valid2 = 0; prep2 = 0;
    fw2 = 32'hA5A5_0001;
    sw2 = 32'h5A5A_0002;
    test_reset();
    test_basic();
    test_wait_row();
    test_toggle();
    test_hold_prep();
    test_midrow_reset();
    test_noe16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
